// File: rtl/tokenizer_pkg.sv
// Shared tokenizer definitions: default geometry, delimiter and packer states.
// The vocabulary matcher imports the same package so both ends agree on
// WORD_LENGTH / DATA_WIDTH without duplicating constants.
package tokenizer_pkg;

    localparam int unsigned WORD_LENGTH_DEF = 32'd3;
    localparam int unsigned DATA_WIDTH_DEF  = 32'd8;
    localparam logic [7:0]  DELIM_DEF       = 8'h20;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Width of a counter that must represent 0..wl inclusive.
    function automatic int unsigned len_w(input int unsigned wl);
        return $clog2(wl + 32'd1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Byte-stream tokenizer front end: splits on DELIM, packs each token
// MSB-first into a zero-padded word and holds it for the matcher until
// it is accepted. Characters beyond WORD_LENGTH are dropped and flagged.
module word_packer
    import tokenizer_pkg::*;
#(
    parameter int unsigned           WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int unsigned           DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] DELIM       = DATA_WIDTH'(DELIM_DEF)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0]    word,
    output logic [$clog2(WORD_LENGTH+1)-1:0]     word_len,
    output logic                                 word_trunc,
    output logic                                 word_last,
    output logic                                 word_valid,
    input  logic                                 word_ready
);

    localparam int unsigned      LEN_W   = len_w(WORD_LENGTH);
    localparam int unsigned      WORD_W  = WORD_LENGTH * DATA_WIDTH;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WORD_LENGTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

    packer_state_t     state_q, state_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              trunc_q, trunc_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              word_valid_q, word_valid_d;

    logic              accept_s;
    logic              is_delim_s;

    // Byte handshake and delimiter decode.
    always_comb begin
        accept_s   = in_valid && in_ready_q;
        is_delim_s = (in_data == DELIM);
    end

    // Next-state, slot write, saturating counter and output-flag computation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        trunc_d = trunc_q;
        last_d  = last_q;

        case (state_q)
            FILL: begin
                if (accept_s) begin
                    if (!is_delim_s) begin
                        if (count_q < LEN_MAX) begin
                            // Slot i lives at the top of the word for i = 0.
                            for (int i = 0; i < int'(WORD_LENGTH); i++) begin
                                word_d[(int'(WORD_LENGTH) - 1 - i) * int'(DATA_WIDTH) +: DATA_WIDTH] =
                                    (count_q == LEN_W'(i)) ? in_data
                                    : word_q[(int'(WORD_LENGTH) - 1 - i) * int'(DATA_WIDTH) +: DATA_WIDTH];
                            end
                            count_d = count_q + LEN_ONE;
                        end else begin
                            trunc_d = 1'b1;
                        end
                    end else begin
                        count_d = count_q;
                    end

                    // Termination uses the count after this byte is applied.
                    if (in_last) begin
                        if (count_d != LEN_ZERO) begin
                            state_d = HOLD;
                            last_d  = 1'b1;
                        end else begin
                            // Stream ended with nothing pending: wipe and stay.
                            state_d = FILL;
                            count_d = LEN_ZERO;
                            word_d  = {WORD_W{1'b0}};
                            trunc_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else if (is_delim_s && (count_q != LEN_ZERO)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end

            HOLD: begin
                if (word_ready) begin
                    state_d = FILL;
                    count_d = LEN_ZERO;
                    word_d  = {WORD_W{1'b0}};
                    trunc_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end

            default: begin
                // Corrupted state encoding: recover to an empty FILL.
                state_d = FILL;
                count_d = LEN_ZERO;
                word_d  = {WORD_W{1'b0}};
                trunc_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        in_ready_d   = (state_d == FILL);
        word_valid_d = (state_d == HOLD);
    end

    // State and output registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            count_q      <= LEN_ZERO;
            word_q       <= {WORD_W{1'b0}};
            trunc_q      <= 1'b0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            trunc_q      <= trunc_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign word       = word_q;
    assign word_len   = count_q;
    assign word_trunc = trunc_q;
    assign word_last  = last_q;
    assign word_valid = word_valid_q;

endmodule
